rtc_time_core: RTL and testbench

// Parametrised time-of-day core for the alarm-clock datapath. It keeps an hours/minutes/seconds count

---
 rtl/rtc_time_core_if.sv | 28 ++
 rtl/rtc_time_core.sv | 134 +++++++++++++
 tb/tb_rtc_time_core.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_time_core_if.sv
// Bus bundle for the time-of-day core: edit/preset controls in, display fields out.
interface rtc_time_core_if;
    logic       time_set;
    logic       inc_hr;
    logic       dec_hr;
    logic       inc_min;
    logic       dec_min;
    logic       load;
    logic [4:0] load_h;
    logic [5:0] load_m;
    logic [5:0] load_s;
    logic [5:0] outh;
    logic [5:0] outm;
    logic [5:0] outs;
    logic       pm;
    logic       set_mode;
    logic       day_pulse;

    modport master (
        output time_set, inc_hr, dec_hr, inc_min, dec_min, load, load_h, load_m, load_s,
        input  outh, outm, outs, pm, set_mode, day_pulse
    );

    modport slave (
        input  time_set, inc_hr, dec_hr, inc_min, dec_min, load, load_h, load_m, load_s,
        output outh, outm, outs, pm, set_mode, day_pulse
    );
endinterface

// File: rtl/rtc_time_core.sv
// Hours/minutes/seconds counter with prescaler, edit mode with per-field inc/dec,
// direct preset load, 12/24-hour display and a midnight rollover pulse.
module rtc_time_core #(
    parameter int TICKS_PER_SEC    = 1,
    parameter int HOUR_24          = 1,
    parameter int CLEAR_SEC_ON_SET = 1
) (
    input  logic           clk_1hz,
    input  logic           rst,
    rtc_time_core_if.slave bus
);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);

    logic [4:0]    h_reg, h_next;
    logic [5:0]    m_reg, m_next;
    logic [5:0]    s_reg, s_next;
    logic [PW-1:0] p_reg, p_next;
    logic          roll_reg, roll_next;
    logic          ts_prev_reg;
    logic [3:0]    btn_prev_reg;
    logic [3:0]    btn;
    logic [3:0]    btn_edge;
    logic [5:0]    disp_h;

    logic [5:0] outh_reg, outm_reg, outs_reg;
    logic       pm_reg, day_pulse_reg;

    // Button order: [3]=inc_hr [2]=dec_hr [1]=inc_min [0]=dec_min
    assign btn = {bus.inc_hr, bus.dec_hr, bus.inc_min, bus.dec_min};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_edge
            assign btn_edge[gi] = btn[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    always_comb begin
        h_next    = h_reg;
        m_next    = m_reg;
        s_next    = s_reg;
        p_next    = p_reg;
        roll_next = 1'b0;
        if (bus.load) begin
            h_next = (bus.load_h > 5'd23) ? 5'd23 : bus.load_h;
            m_next = (bus.load_m > 6'd59) ? 6'd59 : bus.load_m;
            s_next = (bus.load_s > 6'd59) ? 6'd59 : bus.load_s;
            p_next = '0;
        end else if (bus.time_set) begin
            p_next = '0;
            if ((CLEAR_SEC_ON_SET != 0) && !ts_prev_reg)
                s_next = 6'd0;
            // Simultaneous inc and dec on one field cancel out
            case (btn_edge[3:2])
                2'b10:   h_next = (h_reg == 5'd23) ? 5'd0 : h_reg + 5'd1;
                2'b01:   h_next = (h_reg == 5'd0) ? 5'd23 : h_reg - 5'd1;
                default: h_next = h_reg;
            endcase
            case (btn_edge[1:0])
                2'b10:   m_next = (m_reg == 6'd59) ? 6'd0 : m_reg + 6'd1;
                2'b01:   m_next = (m_reg == 6'd0) ? 6'd59 : m_reg - 6'd1;
                default: m_next = m_reg;
            endcase
        end else if (p_reg == P_LAST) begin
            p_next = '0;
            if (s_reg == 6'd59) begin
                s_next = 6'd0;
                if (m_reg == 6'd59) begin
                    m_next = 6'd0;
                    if (h_reg == 5'd23) begin
                        h_next    = 5'd0;
                        roll_next = 1'b1;
                    end else begin
                        h_next = h_reg + 5'd1;
                    end
                end else begin
                    m_next = m_reg + 6'd1;
                end
            end else begin
                s_next = s_reg + 6'd1;
            end
        end else begin
            p_next = p_reg + PW'(1);
        end
    end

    always_comb begin
        disp_h = {1'b0, h_reg};
        if (HOUR_24 == 0) begin
            if (h_reg == 5'd0 || h_reg == 5'd12)
                disp_h = 6'd12;
            else if (h_reg > 5'd12)
                disp_h = {1'b0, h_reg - 5'd12};
        end
    end

    always_ff @(posedge clk_1hz) begin
        if (rst) begin
            h_reg         <= 5'd0;
            m_reg         <= 6'd0;
            s_reg         <= 6'd0;
            p_reg         <= '0;
            roll_reg      <= 1'b0;
            ts_prev_reg   <= 1'b0;
            btn_prev_reg  <= 4'd0;
            outh_reg      <= (HOUR_24 != 0) ? 6'd0 : 6'd12;
            outm_reg      <= 6'd0;
            outs_reg      <= 6'd0;
            pm_reg        <= 1'b0;
            day_pulse_reg <= 1'b0;
        end else begin
            h_reg         <= h_next;
            m_reg         <= m_next;
            s_reg         <= s_next;
            p_reg         <= p_next;
            roll_reg      <= roll_next;
            ts_prev_reg   <= bus.time_set;
            btn_prev_reg  <= btn;
            // Display follows the state one cycle later, pulse aligned with 00:00:00
            outh_reg      <= disp_h;
            outm_reg      <= m_reg;
            outs_reg      <= s_reg;
            pm_reg        <= (h_reg >= 5'd12);
            day_pulse_reg <= roll_reg;
        end
    end

    assign bus.outh      = outh_reg;
    assign bus.outm      = outm_reg;
    assign bus.outs      = outs_reg;
    assign bus.pm        = pm_reg;
    assign bus.set_mode  = ts_prev_reg;
    assign bus.day_pulse = day_pulse_reg;
endmodule

// File: tb/tb_rtc_time_core.sv
// Scoreboard bench for rtc_time_core: two parameterisations driven by the same stimulus,
// checked against a seconds-of-day reference model.
module tb_rtc_time_core;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       ts = 1'b0, ih = 1'b0, dh = 1'b0, im = 1'b0, dm = 1'b0, ld = 1'b0;
    logic [4:0] lh = 5'd0;
    logic [5:0] lm = 6'd0, ls = 6'd0;

    rtc_time_core_if bus0 ();
    rtc_time_core_if bus1 ();

    assign bus0.time_set = ts;  assign bus1.time_set = ts;
    assign bus0.inc_hr   = ih;  assign bus1.inc_hr   = ih;
    assign bus0.dec_hr   = dh;  assign bus1.dec_hr   = dh;
    assign bus0.inc_min  = im;  assign bus1.inc_min  = im;
    assign bus0.dec_min  = dm;  assign bus1.dec_min  = dm;
    assign bus0.load     = ld;  assign bus1.load     = ld;
    assign bus0.load_h   = lh;  assign bus1.load_h   = lh;
    assign bus0.load_m   = lm;  assign bus1.load_m   = lm;
    assign bus0.load_s   = ls;  assign bus1.load_s   = ls;

    rtc_time_core #(.TICKS_PER_SEC(1), .HOUR_24(0), .CLEAR_SEC_ON_SET(1)) dut0 (
        .clk_1hz(clk), .rst(rst), .bus(bus0));
    rtc_time_core #(.TICKS_PER_SEC(4), .HOUR_24(1), .CLEAR_SEC_ON_SET(0)) dut1 (
        .clk_1hz(clk), .rst(rst), .bus(bus1));

    typedef struct packed {
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       pm;
        logic       sm;
        logic       dp;
    } obs_t;

    obs_t exp_q0[$];
    obs_t exp_q1[$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: time kept as seconds since midnight
    int   tps[2] = '{1, 4};
    bit   h24[2] = '{1'b0, 1'b1};
    bit   clr[2] = '{1'b1, 1'b0};
    int   tod[2] = '{0, 0};
    int   pc[2]  = '{0, 0};
    bit   roll[2] = '{1'b0, 1'b0};
    bit   tsp = 1'b0;
    bit   bprev[4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    function automatic obs_t show(int d);
        obs_t e;
        int hr;
        hr = tod[d] / 3600;
        if (h24[d]) e.h = 6'(hr);
        else        e.h = 6'((hr % 12 == 0) ? 12 : hr % 12);
        e.m  = 6'((tod[d] / 60) % 60);
        e.s  = 6'(tod[d] % 60);
        e.pm = (hr >= 12);
        e.sm = ts;
        e.dp = roll[d];
        return e;
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_edge();
        obs_t e;
        int hr, mn, sc, dhr, dmn;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                e = '0;
                e.h = h24[d] ? 6'd0 : 6'd12;
            end else begin
                e = show(d);
            end
            if (d == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);

            if (rst) begin
                tod[d] = 0; pc[d] = 0; roll[d] = 1'b0;
            end else if (ld) begin
                tod[d] = imin(int'(lh), 23) * 3600 + imin(int'(lm), 59) * 60 + imin(int'(ls), 59);
                pc[d] = 0; roll[d] = 1'b0;
            end else if (ts) begin
                hr = tod[d] / 3600;
                mn = (tod[d] / 60) % 60;
                sc = tod[d] % 60;
                if (clr[d] && !tsp) sc = 0;
                dhr = int'(ih && !bprev[0]) - int'(dh && !bprev[1]);
                dmn = int'(im && !bprev[2]) - int'(dm && !bprev[3]);
                hr = (hr + dhr + 24) % 24;
                mn = (mn + dmn + 60) % 60;
                tod[d] = hr * 3600 + mn * 60 + sc;
                pc[d] = 0; roll[d] = 1'b0;
            end else if (pc[d] == tps[d] - 1) begin
                pc[d]   = 0;
                tod[d]  = (tod[d] + 1) % 86400;
                roll[d] = (tod[d] == 0);
            end else begin
                pc[d]   = pc[d] + 1;
                roll[d] = 1'b0;
            end
        end
        if (rst) begin
            tsp = 1'b0;
            bprev = '{1'b0, 1'b0, 1'b0, 1'b0};
        end else begin
            tsp = ts;
            bprev = '{ih, dh, im, dm};
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic do_load(int h, int m, int s);
        ld = 1'b1; lh = 5'(h); lm = 6'(m); ls = 6'(s);
        step();
        ld = 1'b0;
    endtask

    task automatic chk(int d, string name, int act, int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL dut%0d %s: got %0d, expected %0d at %0t", d, name, act, expv, $time);
        end
    endtask

    task automatic chk_obs(int d, obs_t a, obs_t e);
        chk(d, "outh", int'(a.h), int'(e.h));
        chk(d, "outm", int'(a.m), int'(e.m));
        chk(d, "outs", int'(a.s), int'(e.s));
        chk(d, "pm", int'(a.pm), int'(e.pm));
        chk(d, "set_mode", int'(a.sm), int'(e.sm));
        chk(d, "day_pulse", int'(a.dp), int'(e.dp));
    endtask

    // Monitor: every cycle presents a fresh output set, one queued expectation per cycle
    always @(negedge clk) begin
        obs_t a, e;
        if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            a = '{bus0.outh, bus0.outm, bus0.outs, bus0.pm, bus0.set_mode, bus0.day_pulse};
            chk_obs(0, a, e);
        end
        if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            a = '{bus1.outh, bus1.outm, bus1.outs, bus1.pm, bus1.set_mode, bus1.day_pulse};
            chk_obs(1, a, e);
        end
    end

    initial begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(3);

        do_load(23, 59, 58);
        run(10);

        do_load(0, 0, 0);
        run(8);
        ts = 1'b1; step(); ts = 1'b0;
        run(6);

        do_load(10, 30, 45);
        ts = 1'b1; run(2);
        ih = 1'b1; run(5); ih = 1'b0; run(1);
        do_load(10, 0, 45);
        dm = 1'b1; run(2); dm = 1'b0; run(1);
        im = 1'b1; dm = 1'b1; run(2); im = 1'b0; dm = 1'b0;
        ts = 1'b0; run(2);
        ih = 1'b1; run(2); ih = 1'b0; run(2);

        do_load(0, 0, 0);   run(2);
        do_load(12, 0, 0);  run(2);
        do_load(13, 5, 0);  run(2);
        do_load(30, 63, 63); run(2);

        run(3);
        rst = 1'b1; step(); rst = 1'b0;
        run(2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) ts = ~ts;
            if ($urandom_range(0, 9) < 3) ih = ~ih;
            if ($urandom_range(0, 9) < 3) dh = ~dh;
            if ($urandom_range(0, 9) < 3) im = ~im;
            if ($urandom_range(0, 9) < 3) dm = ~dm;
            rst = ($urandom_range(0, 199) == 0);
            ld  = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 1) == 0) begin
                lh = 5'd23; lm = 6'd59; ls = 6'($urandom_range(50, 59));
            end else begin
                lh = 5'($urandom_range(0, 31));
                lm = 6'($urandom_range(0, 63));
                ls = 6'($urandom_range(0, 63));
            end
            step();
        end
        rst = 1'b0; ld = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        vectors++;
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending, expected 0/0", exp_q0.size(), exp_q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
